// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional divide-by-zero fast path is enabled with the SEQ_DIV_DBZ_EN macro.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int CNT_WIDTH     = $clog2(DEFAULT_WIDTH + 1);

    // Iteration counter width for an arbitrary operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // The trial value carries one extra bit so the compare cannot wrap.
    always_comb begin
        trial   = {rem_in, bit_in};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Define SEQ_DIV_DBZ_EN to add the dbz flag and a one-cycle divide-by-zero path.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic             dbz
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic             accept;
    logic             last_iter;
    logic             zero_div;

    assign accept    = start && (state != RUN);
    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_DBZ_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (quo_sr[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = zero_div ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient shift register: dividend
    // bits leave at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            quo_sr <= '0;
            dvs_r  <= '0;
            rem_r  <= '0;
        end else if (accept) begin
            cnt   <= '0;
            dvs_r <= divisor;
            if (zero_div) begin
                quo_sr <= '1;
                rem_r  <= dividend;
            end else begin
                quo_sr <= dividend;
                rem_r  <= '0;
            end
        end else if (state == RUN) begin
            cnt    <= cnt + CW'(1);
            quo_sr <= {quo_sr[WIDTH-2:0], q_bit};
            rem_r  <= rem_step;
        end
    end

`ifdef SEQ_DIV_DBZ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz <= 1'b0;
        end else if (accept) begin
            dbz <= zero_div;
        end
    end
`endif

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = quo_sr;
    assign remainder = rem_r;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH = 16), both with and without SEQ_DIV_DBZ_EN.
module tb_seq_div;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SEQ_DIV_DBZ_EN
    logic         dbz;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    int latency;
    int busyCycles;
    int doneSeen;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQ_DIV_DBZ_EN
        ,
        .dbz       (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge for driving and sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Present one operand pair with a single-cycle start pulse; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen, and busy cycles on the way.
    task automatic waitDone(output int edges, output int busyCnt);
        edges   = 0;
        busyCnt = 0;
        while (!done && edges < 100) begin
            busyCnt += int'(busy);
            tick();
            edges++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset quotient", 32'(quotient), 0);
        checkOutput("reset remainder", 32'(remainder), 0);
`ifdef SEQ_DIV_DBZ_EN
        checkOutput("reset dbz", 32'(dbz), 0);
`endif

        // 100 / 7 = 14 r 2
        applyStimulus(16'd100, 16'd7);
        waitDone(latency, busyCycles);
        checkOutput("100/7 latency", 32'(latency), 32'(W));
        checkOutput("100/7 busy cycles", 32'(busyCycles), 32'(W));
        checkOutput("100/7 quotient", 32'(quotient), 14);
        checkOutput("100/7 remainder", 32'(remainder), 2);
        tick();
        checkOutput("100/7 done pulse width", 32'(done), 0);
        checkOutput("100/7 quotient hold", 32'(quotient), 14);
        checkOutput("100/7 remainder hold", 32'(remainder), 2);

        // Boundary operands
        applyStimulus(16'hFFFF, 16'd1);
        waitDone(latency, busyCycles);
        checkOutput("FFFF/1 quotient", 32'(quotient), 32'h0000_FFFF);
        checkOutput("FFFF/1 remainder", 32'(remainder), 0);
        tick();
        applyStimulus(16'd3, 16'd10);
        waitDone(latency, busyCycles);
        checkOutput("3/10 quotient", 32'(quotient), 0);
        checkOutput("3/10 remainder", 32'(remainder), 3);
        tick();

        // Divide by zero
        applyStimulus(16'd5, 16'd0);
        waitDone(latency, busyCycles);
`ifdef SEQ_DIV_DBZ_EN
        checkOutput("5/0 latency", 32'(latency), 0);
        checkOutput("5/0 busy cycles", 32'(busyCycles), 0);
        checkOutput("5/0 dbz", 32'(dbz), 1);
`else
        checkOutput("5/0 latency", 32'(latency), 32'(W));
        checkOutput("5/0 busy cycles", 32'(busyCycles), 32'(W));
`endif
        checkOutput("5/0 quotient", 32'(quotient), 32'h0000_FFFF);
        checkOutput("5/0 remainder", 32'(remainder), 5);
        tick();
        checkOutput("5/0 done pulse width", 32'(done), 0);
`ifdef SEQ_DIV_DBZ_EN
        applyStimulus(16'd100, 16'd7);
        checkOutput("dbz cleared on accept", 32'(dbz), 0);
        waitDone(latency, busyCycles);
        checkOutput("post-dbz quotient", 32'(quotient), 14);
        tick();
`endif

        // start held through RUN with operands changing every cycle
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd9;
        tick();
        latency = 0;
        while (!done && latency < 100) begin
            dividend = dividend + 16'd37;
            divisor  = divisor + 16'd3;
            tick();
            latency++;
        end
        checkOutput("1000/9 latency", 32'(latency), 32'(W));
        checkOutput("1000/9 quotient", 32'(quotient), 111);
        checkOutput("1000/9 remainder", 32'(remainder), 1);
        dividend = 16'd50;
        divisor  = 16'd6;
        tick();
        start = 1'b0;
        checkOutput("re-accept busy", 32'(busy), 1);
        checkOutput("re-accept done", 32'(done), 0);
        waitDone(latency, busyCycles);
        checkOutput("50/6 latency", 32'(latency), 32'(W));
        checkOutput("50/6 quotient", 32'(quotient), 8);
        checkOutput("50/6 remainder", 32'(remainder), 2);
        tick();

        // Reset in the middle of 200 / 3
        applyStimulus(16'd200, 16'd3);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid-run reset busy", 32'(busy), 0);
        checkOutput("mid-run reset done", 32'(done), 0);
        checkOutput("mid-run reset quotient", 32'(quotient), 0);
        checkOutput("mid-run reset remainder", 32'(remainder), 0);
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            doneSeen += int'(done);
            tick();
        end
        checkOutput("no done after abandon", 32'(doneSeen), 0);
        applyStimulus(16'd200, 16'd3);
        waitDone(latency, busyCycles);
        checkOutput("200/3 latency", 32'(latency), 32'(W));
        checkOutput("200/3 quotient", 32'(quotient), 66);
        checkOutput("200/3 remainder", 32'(remainder), 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
